// File: rtl/vm_pkg.sv
`default_nettype none
// ---- vm_pkg: shared types for the VM capture recorder (rev 1.0) ----
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECORD  = 2'd1,
    ST_READOUT = 2'd2
  } state_t;

  localparam int DEF_POS_W  = 16;
  localparam int DEF_NAME_W = 10;
  localparam int DEF_LVL_W  = 6;
  localparam int DEF_IDX_W  = 6;

  // Record layout at the default configuration; cap_table mirrors it per instance width.
  typedef struct packed {
    logic [DEF_NAME_W-1:0] name;
    logic [DEF_POS_W-1:0]  start_pos;
    logic [DEF_POS_W-1:0]  end_pos;
    logic [DEF_LVL_W-1:0]  level;
    logic [DEF_IDX_W-1:0]  parent;
    logic                  matched;
  } capture_rec_t;

  function automatic int cap_idx_w(input int max_caps);
    return (max_caps <= 2) ? 1 : $clog2(max_caps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cap_table.sv
`default_nettype none
// ---- cap_table: capture record register file, open/close write ports, two read ports (rev 1.0) ----
module cap_table
  import vm_pkg::*;
#(
  parameter int MAX_CAPS = 64,
  parameter int POS_W    = 16,
  parameter int NAME_W   = 10,
  parameter int LVL_W    = 6,
  parameter int IDX_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open_we,
  input  logic [IDX_W-1:0]  open_addr,
  input  logic [NAME_W-1:0] open_name,
  input  logic [POS_W-1:0]  open_pos,
  input  logic [IDX_W-1:0]  open_parent,
  input  logic [LVL_W-1:0]  open_level,
  input  logic              close_we,
  input  logic [IDX_W-1:0]  close_addr,
  input  logic [POS_W-1:0]  close_pos,
  input  logic [IDX_W-1:0]  lvl_addr,
  output logic [LVL_W-1:0]  lvl_level,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [NAME_W-1:0] rd_name,
  output logic [POS_W-1:0]  rd_start,
  output logic [POS_W-1:0]  rd_end,
  output logic [LVL_W-1:0]  rd_level,
  output logic [IDX_W-1:0]  rd_parent,
  output logic              rd_matched,
  output logic              rec0_matched,
  output logic [POS_W-1:0]  rec0_end
);

  typedef struct packed {
    logic [NAME_W-1:0] name;
    logic [POS_W-1:0]  start_pos;
    logic [POS_W-1:0]  end_pos;
    logic [LVL_W-1:0]  level;
    logic [IDX_W-1:0]  parent;
    logic              matched;
  } rec_t;

  rec_t mem [MAX_CAPS];

  // Open and close never target the same entry: close only hits indices below count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CAPS; i++) mem[i] <= '0;
    end else begin
      if (open_we) begin
        mem[open_addr] <= '{name: open_name, start_pos: open_pos, end_pos: '0,
                            level: open_level, parent: open_parent, matched: 1'b0};
      end
      if (close_we) begin
        mem[close_addr].end_pos <= close_pos;
        mem[close_addr].matched <= 1'b1;
      end
    end
  end

  assign lvl_level    = mem[lvl_addr].level;
  assign rd_name      = mem[rd_addr].name;
  assign rd_start     = mem[rd_addr].start_pos;
  assign rd_end       = mem[rd_addr].end_pos;
  assign rd_level     = mem[rd_addr].level;
  assign rd_parent    = mem[rd_addr].parent;
  assign rd_matched   = mem[rd_addr].matched;
  assign rec0_matched = mem[0].matched;
  assign rec0_end     = mem[0].end_pos;

endmodule
`default_nettype wire

// File: rtl/vm_capture_recorder.sv
`default_nettype none
// ---- vm_capture_recorder: capture bookkeeping and record readout behind the RPL VM core (rev 1.0) ----
module vm_capture_recorder
  import vm_pkg::*;
#(
  parameter  int MAX_CAPS = 64,
  parameter  int POS_W    = 16,
  parameter  int NAME_W   = 10,
  parameter  int LVL_W    = 6,
  localparam int IDX_W    = cap_idx_w(MAX_CAPS),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              open_valid,
  input  logic [NAME_W-1:0] open_name,
  input  logic [POS_W-1:0]  open_pos,
  input  logic [IDX_W-1:0]  open_parent,
  output logic [IDX_W-1:0]  open_idx,
  input  logic              close_valid,
  input  logic [IDX_W-1:0]  close_idx,
  input  logic [POS_W-1:0]  close_pos,
  output logic [IDX_W-1:0]  close_parent,
  output logic              notify_valid,
  output logic [IDX_W-1:0]  notify_idx,
  input  logic              match_done,
  output logic              matched,
  output logic [POS_W-1:0]  match_end,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [NAME_W-1:0] out_name,
  output logic [POS_W-1:0]  out_start,
  output logic [POS_W-1:0]  out_end,
  output logic [LVL_W-1:0]  out_level,
  output logic [IDX_W-1:0]  out_parent,
  output logic              out_matched,
  output logic              out_last,
  output logic [CNT_W-1:0]  count
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             full;
  logic             open_acc;
  logic             close_acc;
  logic [CNT_W-1:0] count_nxt;
  logic [LVL_W-1:0] parent_level;
  logic [LVL_W-1:0] new_level;
  logic [IDX_W-1:0] rd_addr;
  logic [IDX_W-1:0] rd_parent;
  logic             rec0_matched;
  logic [POS_W-1:0] rec0_end;

  assign full      = (count == CNT_W'(MAX_CAPS));
  assign open_acc  = (state == ST_RECORD) && !clear && open_valid && !full;
  assign close_acc = (state == ST_RECORD) && !clear && close_valid && ({1'b0, close_idx} < count);
  assign count_nxt = open_acc ? count + CNT_W'(1) : count;
  assign open_idx  = count[IDX_W-1:0];
  assign new_level = (count == '0) ? '0 :
                     (parent_level == '1) ? parent_level : parent_level + LVL_W'(1);

  // The shared read port serves close_parent while recording and the readout mux otherwise.
  assign rd_addr      = (state == ST_READOUT) ? ptr : close_idx;
  assign close_parent = rd_parent;
  assign out_parent   = rd_parent;
  assign out_idx      = ptr;
  assign out_last     = ({1'b0, ptr} == count - CNT_W'(1));
  assign matched      = (count != '0) && rec0_matched;
  assign match_end    = (count != '0) ? rec0_end : '0;

  cap_table #(
    .MAX_CAPS(MAX_CAPS), .POS_W(POS_W), .NAME_W(NAME_W), .LVL_W(LVL_W), .IDX_W(IDX_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .open_we     (open_acc),
    .open_addr   (count[IDX_W-1:0]),
    .open_name   (open_name),
    .open_pos    (open_pos),
    .open_parent (open_parent),
    .open_level  (new_level),
    .close_we    (close_acc),
    .close_addr  (close_idx),
    .close_pos   (close_pos),
    .lvl_addr    (open_parent),
    .lvl_level   (parent_level),
    .rd_addr     (rd_addr),
    .rd_name     (out_name),
    .rd_start    (out_start),
    .rd_end      (out_end),
    .rd_level    (out_level),
    .rd_parent   (rd_parent),
    .rd_matched  (out_matched),
    .rec0_matched(rec0_matched),
    .rec0_end    (rec0_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      ptr          <= '0;
      overflow     <= 1'b0;
      notify_valid <= 1'b0;
      notify_idx   <= '0;
      out_valid    <= 1'b0;
    end else begin
      notify_valid <= 1'b0;
      if (clear) begin
        state     <= ST_RECORD;
        count     <= '0;
        overflow  <= 1'b0;
        ptr       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_RECORD: begin
            count <= count_nxt;
            if (open_valid && full) overflow <= 1'b1;
            if (close_acc) begin
              notify_valid <= 1'b1;
              notify_idx   <= close_idx;
            end
            if (match_done) begin
              ptr <= '0;
              if (count_nxt == '0) begin
                state <= ST_IDLE;
              end else begin
                state     <= ST_READOUT;
                out_valid <= 1'b1;
              end
            end
          end
          ST_READOUT: begin
            if (out_valid && out_ready) begin
              if (out_last) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                ptr       <= '0;
              end else begin
                ptr <= ptr + IDX_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vm_capture_recorder.md
# vm_capture_recorder

Capture bookkeeping stage directly downstream of the RPL VM core. It consumes the core's open_capture and close_capture events and keeps a table of capture records (name, start/end position, level, parent, matched). When the match ends, it streams the records to the result consumer over a valid/ready handshake. It replaces the growable capture list of the software VM with a bounded register table.

## Interface
Parameters:
- MAX_CAPS, 64, capacity of the capture table (power of two, ≥ 2)
- POS_W, 16, input position width
- NAME_W, 10, symbol-table index width for capture names
- LVL_W, 6, nesting level width

Ports:
- clk  in  1  clock; the block has one clock domain
- rst  in  1  asynchronous, active-high reset
- clear  in  1  start of a new match: empties the table
- open_valid  in  1  open_capture event
- open_name  in  NAME_W  capture name symbol index
- open_pos  in  POS_W  start position
- open_parent  in  $clog2(MAX_CAPS)  current capidx of the core
- open_idx  out  $clog2(MAX_CAPS)  index the next open will get (equals count)
- close_valid  in  1  close_capture event
- close_idx  in  $clog2(MAX_CAPS)  capidx being closed
- close_pos  in  POS_W  end position
- close_parent  out  $clog2(MAX_CAPS)  parent of close_idx (combinational table read)
- notify_valid  out  1  one-cycle pulse after each accepted close
- notify_idx  out  $clog2(MAX_CAPS)  closed index
- match_done  in  1  core reached end or halt
- matched  out  1  record 0 matched flag (0 when the table is empty)
- match_end  out  POS_W  record 0 end_pos
- overflow  out  1  sticky: an open was dropped because the table was full
- out_valid  out  1  readout record valid
- out_ready  in  1  consumer accepts the record
- out_idx, out_name, out_start, out_end, out_level, out_parent, out_matched, out_last  out  …  readout record fields
- count  out  $clog2(MAX_CAPS)+1  records currently stored

## Operation
- States: IDLE, RECORD, READOUT. Reset puts the block in IDLE.
- clear in any state moves to RECORD and sets count=0 and overflow=0. It aborts a readout in progress: out_valid drops next cycle.
- RECORD, open_valid:
  - If count<MAX_CAPS, write record[count] = {name, start=open_pos, end=0, matched=0, parent=open_parent, level}, then count++.
  - level = 0 if count==0; otherwise level[open_parent]+1, saturating at 2^LVL_W−1.
  - If count==MAX_CAPS, drop the event and set overflow.
- RECORD, close_valid: write end=close_pos and matched=1 into record[close_idx].
  - If close_idx≥count, ignore the close and raise no notify.
  - Re-closing an entry overwrites end.
- open_valid and close_valid in the same cycle: both are applied. The close uses the pre-open table, so close_idx==count is ignored.
- Events in IDLE or READOUT are ignored.
- match_done in RECORD moves to READOUT with the read pointer at 0. If count==0, go directly to IDLE.
- READOUT: present record[ptr]; out_last = (ptr==count−1).
  - On out_valid&&out_ready, ptr++.
  - On the last transfer, go to IDLE.
- Backtracking in the core does not truncate the table. Records opened on a failed branch stay with matched=0, matching software semantics.

## Timing
- Reset values: every output is 0, state IDLE, all records zeroed.
- open_idx and close_parent are combinational from registered state. The core uses them in the same cycle as the event.
- A table write becomes visible on the next cycle. count updates one cycle after open_valid.
- notify_valid/notify_idx are asserted exactly one cycle after an accepted close.
- matched/match_end track record 0 continuously, with 1-cycle latency after its close.
- Readout throughput is 1 record per cycle when out_ready is held high.
- out_* fields hold stable while out_valid && !out_ready.
- After match_done, out_valid rises on the next cycle.

## Structure
- Shared package vm_pkg holds:
  - capture_rec_t struct {name, start_pos, end_pos, level, parent, matched}
  - state enum
  - CAP_IDX_W derivation function
- The record table is a sub-module named cap_table: a register file with one write-open port, one write-close port, and two combinational read ports (parent level, close_parent/readout mux).
- The FSM and readout logic live in the top.

## Test plan
- Reset mid-READOUT (rst pulse at record 2 of 4) -> out_valid=0, count=0, state IDLE; the next clear followed by open at pos 0 gives open_idx 0.
- clear; open(name 5, pos 0, parent 0); open(name 7, pos 3, parent 0); close(1, pos 6); close(0, pos 9); match_done; out_ready=1 -> two records {5,0,9,lvl0,matched}, {7,3,6,lvl1,parent0,matched}; out_last on the second; matched=1, match_end=9; notify pulses with idx 1 then 0.
- Failed branch: open idx1 at pos 2, never closed, then open idx2 -> readout shows idx1 matched=0, end=0.
- MAX_CAPS=4: five opens -> count=4, overflow=1, the 5th event is dropped, and open_idx stays at 4 (wraps to 0 in index width, documented).
- Same-cycle open and close(close_idx=count) -> open is accepted, the close is ignored, no notify.
- Back-pressure: out_ready toggles 1,0,0,1 during readout -> each record is held stable while stalled, 4 transfers total, no skips or duplicates.
